// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo -- PS/2 device-to-host receiver with a first-word fall-through
// byte FIFO.
//
// ps2_clk/ps2_data are synchronized into clk25. ps2_clk is then deglitched:
// a level change is accepted only after FILTER_LEN consecutive identical
// samples. Each 1->0 transition of the filtered clock samples the
// synchronized data line. A framing FSM (IDLE/DATA/PARITY/STOP) assembles
// 11-bit frames. Good bytes are pushed into the FIFO one cycle after the
// stop-bit edge.
//
// Build option:
//   PS2_PARITY_CHECK_EN  When defined, a frame is accepted only if data plus
//                        parity hold an odd number of ones. When undefined,
//                        the parity bit is sampled but ignored.
//
// Parameters:
//   FIFO_DEPTH      bytes buffered (power of two, >= 2)
//   FILTER_LEN      stable samples needed to accept a ps2_clk level change
//   TIMEOUT_CYCLES  idle clk25 cycles inside a frame before abort
//
// Ports:
//   clk25      sole clock, rising edge
//   reset      synchronous, active-high
//   ps2_clk    asynchronous PS/2 clock from device
//   ps2_data   asynchronous PS/2 data from device
//   rx_data    byte at FIFO head; holds the last popped value while empty
//   rx_valid   FIFO non-empty
//   rx_ready   consumer accept; pop when rx_valid && rx_ready
//   count      FIFO occupancy
//   frame_err  1-cycle pulse on a rejected or timed-out frame
//   overflow   1-cycle pulse when a good byte is dropped (FIFO full)
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic                          clk25,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------------
  // Synchronizers and ps2_clk glitch filter (all idle at bus level 1)
  // ---------------------------------------------------------------------
  logic           clk_s1_q, clk_s2_q;
  logic           dat_s1_q, dat_s2_q;
  logic           clk_f_q, clk_f_d;
  logic           clk_f_prev_q;
  logic [FCW-1:0] flt_cnt_q, flt_cnt_d;
  logic           fall;

  // flt_cnt_q counts consecutive samples that disagree with the filtered
  // level. The level flips once FILTER_LEN samples in a row disagree.
  always_comb begin
    clk_f_d   = clk_f_q;
    flt_cnt_d = '0;
    if (clk_s2_q != clk_f_q) begin
      if (flt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        clk_f_d   = clk_s2_q;
        flt_cnt_d = '0;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      clk_f_q      <= 1'b1;
      clk_f_prev_q <= 1'b1;
      flt_cnt_q    <= '0;
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= ps2_data;
      dat_s2_q     <= dat_s1_q;
      clk_f_q      <= clk_f_d;
      clk_f_prev_q <= clk_f_q;
      flt_cnt_q    <= flt_cnt_d;
    end
  end

  // Filtered clock has just gone 1->0. Data is sampled from dat_s2_q on
  // this same cycle.
  assign fall = clk_f_prev_q & ~clk_f_q;

  // ---------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          push_q, push_d;
  logic          ferr_q, ferr_d;
  logic          good;

`ifdef PS2_PARITY_CHECK_EN
  assign good = dat_s2_q & (^{par_q, shift_q});
`else
  assign good = dat_s2_q;
`endif

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tmr_d    = '0;
    push_d   = 1'b0;
    ferr_d   = 1'b0;

    if (state_q != IDLE && !fall) begin
      if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
        // Bus went quiet mid-frame: drop partial data.
        state_d  = IDLE;
        bitcnt_d = '0;
        shift_d  = '0;
        ferr_d   = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};  // LSB arrives first
          if (bitcnt_q == 3'd7) begin
            state_d  = PARITY;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          push_d  = good;
          ferr_d  = ~good;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmr_q    <= '0;
      push_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmr_q    <= tmr_d;
      push_q   <= push_d;
      ferr_q   <= ferr_d;
    end
  end

  assign frame_err = ferr_q;

  // ---------------------------------------------------------------------
  // First-word fall-through FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    last_q;
  logic          ovf_q;
  logic          full, pop, wr_en;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign rx_valid = (count_q != '0);
  assign pop      = rx_valid & rx_ready;
  // A pop frees the head slot in the same cycle, so a push is accepted
  // even when full. With wr_ptr == rd_ptr, the head is read before the
  // write lands.
  assign wr_en    = push_q & (~full | pop);

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (wr_en) mem[wr_ptr_q] <= shift_q;
  end

  // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH naturally.
  always_ff @(posedge clk25) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem[rd_ptr_q];
      end
      count_q <= count_d;
      ovf_q   <= push_q & full & ~pop;
    end
  end

  // While empty, present the last byte handed out (0 after reset).
  assign rx_data  = rx_valid ? mem[rd_ptr_q] : last_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
